// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50%-duty clock divider with glitch-free
// run-time divisor changes, clean low-phase start/stop, a rising-edge strobe
// and a running status.
// Optional feature macro: CLKDIV_TICK_FALL_EN adds the tick_fall output, a
// one-cycle strobe in the first cycle clk_out is low after each falling toggle.
module clk_div_prog #(
  parameter int CLK_HZ = 100000000,
  parameter int OUT_HZ = 10000,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_we,
  input  logic [CNT_W-1:0] div_half,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             running,
`ifdef CLKDIV_TICK_FALL_EN
  output logic             tick_fall,
`endif
  output logic             pend
);

  localparam int DEF_HALF = CLK_HZ / (2 * OUT_HZ);

  // The default half-period must be representable and non-zero.
  if ((DEF_HALF < 1) || (longint'(DEF_HALF) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_def_half
    $error("clk_div_prog: DEF_HALF=%0d out of range for CNT_W=%0d", DEF_HALF, CNT_W);
  end

  localparam logic [CNT_W-1:0] DEF_HALF_V = CNT_W'(DEF_HALF);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A zero half-period has no meaning; the fastest legal rate is half=1.
  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half_cur;
  logic [CNT_W-1:0] r_half_pend;
  logic             r_pend;
  logic             r_clk_out;
  logic [0:0]       r_state;
  logic             r_tick_rise;

  logic [CNT_W-1:0] w_wr_half;
  logic             w_run;
  logic             w_tc;
  logic             w_stop_low;
  logic             w_rise;
  logic             w_fall;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_half_cur_nxt;
  logic [CNT_W-1:0] w_half_pend_nxt;
  logic             w_pend_nxt;
  logic             w_clk_nxt;
  logic [0:0]       w_state_nxt;

  assign w_wr_half  = clamp_half(div_half);
  assign w_run      = (r_state == ST_RUN);
  assign w_tc       = (r_cnt == (r_half_cur - CNT_W'(1)));
  // Stopping from the low phase is immediate; from the high phase it waits
  // for the terminal count so the last high pulse is never truncated.
  assign w_stop_low = w_run && !en && !r_clk_out;
  assign w_rise     = w_run && w_tc && !r_clk_out && en;
  assign w_fall     = w_run && w_tc && r_clk_out;

  // Next-state logic for the counter, output phase, divisor and run state.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_clk_nxt       = r_clk_out;
    w_half_cur_nxt  = r_half_cur;
    w_half_pend_nxt = r_half_pend;
    w_pend_nxt      = r_pend;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (en) begin
          w_state_nxt = ST_RUN;
        end
        // No output activity to disturb, so divisors take effect at once.
        if (div_we) begin
          w_half_cur_nxt  = w_wr_half;
          w_half_pend_nxt = w_wr_half;
          w_pend_nxt      = 1'b0;
        end else if (r_pend) begin
          w_half_cur_nxt = r_half_pend;
          w_pend_nxt     = 1'b0;
        end
      end
      default: begin
        if (w_stop_low) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_tc) begin
          w_cnt_nxt = '0;
          w_clk_nxt = !r_clk_out;
          if (r_clk_out) begin
            if (!en) begin
              w_state_nxt = ST_IDLE;
            end
            // Falling toggle: the only safe point to switch the half-period.
            // It uses the pending state from before any write this cycle.
            if (r_pend) begin
              w_half_cur_nxt = r_half_pend;
              w_pend_nxt     = 1'b0;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        // A write while running is parked until the next falling toggle.
        if (div_we) begin
          w_half_pend_nxt = w_wr_half;
          w_pend_nxt      = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset clears everything, including a parked divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_clk_out   <= 1'b0;
      r_half_cur  <= DEF_HALF_V;
      r_half_pend <= DEF_HALF_V;
      r_pend      <= 1'b0;
      r_tick_rise <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_clk_out   <= w_clk_nxt;
      r_half_cur  <= w_half_cur_nxt;
      r_half_pend <= w_half_pend_nxt;
      r_pend      <= w_pend_nxt;
      r_tick_rise <= w_rise;
    end
  end

`ifdef CLKDIV_TICK_FALL_EN
  logic r_tick_fall;

  // Falling strobe, including the toggle that ends a high-phase stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_fall <= 1'b0;
    end else begin
      r_tick_fall <= w_fall;
    end
  end

  assign tick_fall = r_tick_fall;
`else
  logic w_fall_unused;
  assign w_fall_unused = w_fall;
`endif

  assign clk_out   = r_clk_out;
  assign tick_rise = r_tick_rise;
  assign running   = (r_state == ST_RUN);
  assign pend      = r_pend;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog with CLK_HZ=100, OUT_HZ=10 (default half = 5).
// Stimulus pushes expected clk_out edges (level, clk cycle) into a queue; a
// monitor pops and compares whenever clk_out changes, and also checks the
// strobes against the observed edges every cycle.
module tb_clk_div_prog;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             div_we;
  logic [CNT_W-1:0] div_half;
  logic             clk_out;
  logic             tick_rise;
  logic             running;
  logic             pend;
`ifdef CLKDIV_TICK_FALL_EN
  logic             tick_fall;
`endif

  clk_div_prog #(
    .CLK_HZ(100),
    .OUT_HZ(10),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_we   (div_we),
    .div_half (div_half),
    .clk_out  (clk_out),
    .tick_rise(tick_rise),
    .running  (running),
`ifdef CLKDIV_TICK_FALL_EN
    .tick_fall(tick_fall),
`endif
    .pend     (pend)
  );

  typedef struct {
    logic lvl;
    int   cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic in_rst;
  logic prev_clk;
  logic rose;
  logic fell;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: after the k-th rising edge, cyc == k.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input logic lvl, input int at);
    ev_t e;
    e.lvl = lvl;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges, checked before any edge.
  task automatic async_reset();
    in_rst = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_clk_out", 32'(clk_out), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_tick_rise", 32'(tick_rise), 0);
`ifdef CLKDIV_TICK_FALL_EN
    chk("rst_tick_fall", 32'(tick_fall), 0);
`endif
    en     = 1'b0;
    div_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;
  endtask

  // Monitor: scoreboard for clk_out edges plus per-cycle strobe checks.
  initial begin
    ev_t e;
    prev_clk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || in_rst) begin
        prev_clk = clk_out;
      end else begin
        rose = clk_out && !prev_clk;
        fell = !clk_out && prev_clk;
        if (clk_out !== prev_clk) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL edge_unexpected: clk_out went to %0d at cyc %0d, none expected", clk_out, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("edge_level", 32'(clk_out), 32'(e.lvl));
            chk("edge_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
        chk("tick_rise", 32'(tick_rise), 32'(rose));
`ifdef CLKDIV_TICK_FALL_EN
        chk("tick_fall", 32'(tick_fall), 32'(fell));
        chk("tick_overlap", 32'(tick_rise && tick_fall), 0);
`endif
        prev_clk = clk_out;
      end
    end
  end

  initial begin
    int c;
    rst      = 1'b1;
    in_rst   = 1'b1;
    en       = 1'b0;
    div_we   = 1'b0;
    div_half = '0;
    repeat (3) @(negedge clk);
    chk("init_clk_out", 32'(clk_out), 0);
    chk("init_running", 32'(running), 0);
    chk("init_pend", 32'(pend), 0);
    chk("init_tick_rise", 32'(tick_rise), 0);
    rst = 1'b0;
    @(negedge clk);
    in_rst = 1'b0;

    // Default rate, then a run-time change to half=3 written in a high phase,
    // then a stop requested during a low phase.
    c  = cyc;
    en = 1'b1;
    push_ev(1'b1, c + 6);  push_ev(1'b0, c + 11);
    push_ev(1'b1, c + 16); push_ev(1'b0, c + 21);
    push_ev(1'b1, c + 24); push_ev(1'b0, c + 27);
    push_ev(1'b1, c + 30); push_ev(1'b0, c + 33);
    wait_to(c + 1);
    chk("s1_running", 32'(running), 1);
    wait_to(c + 17);
    div_we = 1'b1; div_half = 8'd3;
    wait_to(c + 18);
    div_we = 1'b0;
    chk("s1_pend_set", 32'(pend), 1);
    wait_to(c + 20);
    chk("s1_pend_hold", 32'(pend), 1);
    wait_to(c + 21);
    chk("s1_pend_clear", 32'(pend), 0);
    wait_to(c + 33);
    en = 1'b0;
    wait_to(c + 34);
    chk("s1_stop_low_running", 32'(running), 0);
    chk("s1_stop_low_clk", 32'(clk_out), 0);

    // Clamp: div_half=0 while idle gives half=1, period 2; stop from high.
    c      = cyc;
    div_we = 1'b1; div_half = 8'd0;
    wait_to(c + 1);
    div_we = 1'b0;
    chk("s2_pend_idle", 32'(pend), 0);
    en = 1'b1;
    push_ev(1'b1, c + 3); push_ev(1'b0, c + 4);
    push_ev(1'b1, c + 5); push_ev(1'b0, c + 6);
    push_ev(1'b1, c + 7); push_ev(1'b0, c + 8);
    wait_to(c + 2);
    chk("s2_running", 32'(running), 1);
    wait_to(c + 7);
    en = 1'b0;
    wait_to(c + 8);
    chk("s2_stop_running", 32'(running), 0);

    // Write coincident with a falling toggle waits a full period; then a
    // dropped-and-restored en, then an asynchronous reset mid-high-phase.
    async_reset();
    c  = cyc;
    en = 1'b1;
    push_ev(1'b1, c + 6);  push_ev(1'b0, c + 11);
    push_ev(1'b1, c + 16); push_ev(1'b0, c + 21);
    push_ev(1'b1, c + 23); push_ev(1'b0, c + 25);
    push_ev(1'b1, c + 27); push_ev(1'b0, c + 29);
    push_ev(1'b1, c + 31);
    wait_to(c + 10);
    div_we = 1'b1; div_half = 8'd2;
    wait_to(c + 11);
    div_we = 1'b0;
    chk("s3_pend_coincident", 32'(pend), 1);
    chk("s3_clk_low", 32'(clk_out), 0);
    wait_to(c + 20);
    chk("s3_pend_wait", 32'(pend), 1);
    wait_to(c + 21);
    chk("s3_pend_applied", 32'(pend), 0);
    wait_to(c + 27);
    en = 1'b0;
    wait_to(c + 28);
    en = 1'b1;
    wait_to(c + 31);
    div_we = 1'b1; div_half = 8'd4;
    wait_to(c + 32);
    div_we = 1'b0;
    chk("s3_pend_before_rst", 32'(pend), 1);
    chk("s3_high_before_rst", 32'(clk_out), 1);
    async_reset();

    // Clean stop requested two cycles into a high phase at the default rate.
    c  = cyc;
    en = 1'b1;
    push_ev(1'b1, c + 6); push_ev(1'b0, c + 11);
    wait_to(c + 7);
    en = 1'b0;
    wait_to(c + 10);
    chk("s5_running_in_stop", 32'(running), 1);
    chk("s5_high_in_stop", 32'(clk_out), 1);
    wait_to(c + 11);
    chk("s5_stopped", 32'(running), 0);
    chk("s5_low_after_stop", 32'(clk_out), 0);
    wait_to(c + 20);
    chk("edges_all_seen", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
